adma_as_tx_sched: RTL and testbench
===================================

// Module: adma_as_tx_sched
// PURPOSE
//  Shares the AXI-stream TX issue path between CH_NUM DMA channels using round-robin arbitration.
//  Splits each granted TX into num_atx AXI transactions (ATXs) and raises atx_last on the final one.
//  Caps outstanding ATXs at ATX_NUM_OSTD.
//  Returns the per-TX tx_done from the TX status tracker to the originating channel, using an in-order channel-ID queue.
// PARAMETERS
//  CH_NUM        4   number of requesting channels (>=2)
//  DMA_LENGTH_W  16  width of ATX-count fields
//  ATX_NUM_OSTD  4   max outstanding ATXs, and depth of the channel-ID queue (max TXs in flight)
//  CH_ID_W = $clog2(CH_NUM) (localparam); OSTD_W = $clog2(ATX_NUM_OSTD+1) (localparam)
// PORTS
//  clk             in   1                    clock, all logic on rising edge
//  rst_n           in   1                    asynchronous active-low reset
//  ch_req_vld      in   CH_NUM               channel i has a TX pending
//  ch_req_num_atx  in   CH_NUM*DMA_LENGTH_W  ATX count of channel i's TX; slice i = [i*DMA_LENGTH_W +: DMA_LENGTH_W]
//  ch_req_rdy      out  CH_NUM               one-hot grant pulse; TX accepted this cycle
//  ch_done         out  CH_NUM               one-hot pulse; channel's oldest TX completed
//  atx_vld         out  1                    ATX issue request towards the AXI address path
//  atx_rdy         in   1                    AXI address path accepts the ATX
//  atx_last        out  1                    current ATX is the last of its TX (valid with atx_vld)
//  atx_ch_id       out  CH_ID_W              channel owning the current ATX
//  atx_start       out  1                    atx_vld & atx_rdy (drives the status tracker's atx_start)
//  atx_done        in   1                    one ATX completed (B/last-beat seen)
//  tx_done         in   1                    status tracker reports the oldest TX complete
//  err             out  1                    sticky protocol-error flag
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr_ptr=0; ostd_cnt=0; ID queue empty; err=0.
//  The reset asynchronously aborts any TX mid-issue. No partial state survives.
//  FSM IDLE:
//   - If |ch_req_vld and the ID queue is not full: grant the first requesting channel at or after rr_ptr, searching upward with wrap.
//   - Grant is combinational: ch_req_rdy[g]=1 in the same cycle.
//   - Latch rem_cnt = num_atx[g] (a value of 0 is clamped to 1) and cur_id=g. Push g into the ID queue. Go to ISSUE.
//   - If the ID queue is full: no grant; stay in IDLE.
//  FSM ISSUE:
//   - atx_vld = (ostd_cnt < ATX_NUM_OSTD); atx_ch_id=cur_id; atx_last = (rem_cnt==1).
//   - On atx_start: rem_cnt -= 1.
//   - If atx_last on that handshake: go to IDLE and set rr_ptr = cur_id+1 (mod CH_NUM).
//   - atx_vld must not drop without a handshake, except on reset.
//   - The earliest atx_vld is the cycle after the grant. No grant occurs while in ISSUE (TXs are never interleaved).
//  ostd_cnt (OSTD_W bits):
//   - +1 on atx_start, -1 on atx_done. Both in the same cycle: value holds.
//   - atx_done while ostd_cnt==0 (with no atx_start that cycle): counter stays 0 and err is set.
//  ID queue: ATX_NUM_OSTD-entry circular FIFO with wrapping read/write pointers and an occupancy count.
//   - Push on grant; pop on tx_done.
//   - Push and pop in the same cycle are both performed, so occupancy holds; this is legal when full or empty only if the pop is valid.
//  ch_done:
//   - ch_done[head_id] = tx_done & ~empty, combinational, same cycle as tx_done.
//   - tx_done while the queue is empty: ignored, err is set.
//  Ordering: TXs are issued whole and in grant order, so tx_done order equals queue order.
//  err: sticky until reset; it has no effect on operation.
// TESTING
//  1. A single channel 1 request with num_atx=3 and atx_rdy=1:
//     - grant in cycle 0 (ch_req_rdy=4'b0010);
//     - atx_start in cycles 1-3, with atx_last only in cycle 3 and atx_ch_id=1;
//     - tx_done then gives ch_done=4'b0010.
//  2. All 4 channels requesting continuously, num_atx=1 each, prompt done:
//     - grant order is 0,1,2,3,0, confirming round-robin and wrap;
//     - no ch_req_rdy while any channel is in ISSUE.
//  3. Outstanding cap: num_atx=6, atx_rdy=1, no atx_done:
//     - exactly 4 atx_start, then atx_vld=0;
//     - one atx_done pulse gives exactly one more issue.
//  4. Queue full: 4 TXs issued, no tx_done:
//     - a fifth request gets no grant;
//     - tx_done gives ch_done for the first-granted channel;
//     - the grant and the pop in the same cycle leave the queue full.
//  5. num_atx=0 on channel 2: exactly one ATX issued with atx_last=1.
//     Then atx_done with ostd_cnt=0, and tx_done with the queue empty: err=1, counters unchanged.
//  6. Assert rst_n low in the middle of ISSUE (rem_cnt=2):
//     - all outputs 0 immediately;
//     - after release, the next grant starts from channel 0.

Source files
------------

// File: rtl/adma_as_tx_sched_if.sv
// Channel request/done and ATX issue/status signals between the TX scheduler and its neighbours.
interface adma_as_tx_sched_if #(
  parameter int unsigned CH_NUM       = 4,
  parameter int unsigned DMA_LENGTH_W = 16
);
  localparam int unsigned CH_ID_W = $clog2(CH_NUM);

  logic [CH_NUM-1:0]              ch_req_vld;
  logic [CH_NUM*DMA_LENGTH_W-1:0] ch_req_num_atx;
  logic [CH_NUM-1:0]              ch_req_rdy;
  logic [CH_NUM-1:0]              ch_done;
  logic                           atx_vld;
  logic                           atx_rdy;
  logic                           atx_last;
  logic [CH_ID_W-1:0]             atx_ch_id;
  logic                           atx_start;
  logic                           atx_done;
  logic                           tx_done;
  logic                           err;

  modport master (
    input  ch_req_vld, ch_req_num_atx, atx_rdy, atx_done, tx_done,
    output ch_req_rdy, ch_done, atx_vld, atx_last, atx_ch_id, atx_start, err
  );

  modport slave (
    output ch_req_vld, ch_req_num_atx, atx_rdy, atx_done, tx_done,
    input  ch_req_rdy, ch_done, atx_vld, atx_last, atx_ch_id, atx_start, err
  );
endinterface

// File: rtl/adma_as_tx_sched.sv
// Round-robin TX scheduler: splits granted TXs into ATXs, caps outstanding ATXs,
// and routes tx_done back to the originating channel through an in-order ID queue.
module adma_as_tx_sched #(
  parameter int unsigned CH_NUM       = 4,
  parameter int unsigned DMA_LENGTH_W = 16,
  parameter int unsigned ATX_NUM_OSTD = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  adma_as_tx_sched_if.master  bus
);
  localparam int unsigned CH_ID_W = $clog2(CH_NUM);
  localparam int unsigned OSTD_W  = $clog2(ATX_NUM_OSTD + 1);
  localparam int unsigned QPTR_W  = (ATX_NUM_OSTD > 1) ? $clog2(ATX_NUM_OSTD) : 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                  state_q, state_d;
  logic [DMA_LENGTH_W-1:0] rem_q, rem_d, req_num;
  logic [CH_ID_W-1:0]      cur_id_q, cur_id_d, rr_q, rr_d, gnt_id, head_id;
  logic                    gnt_found, grant, pop;
  logic                    atx_vld_c, atx_last_c, atx_start_c;
  logic [OSTD_W-1:0]       ostd_q;
  logic                    err_q;

  logic [CH_ID_W-1:0]      id_mem [ATX_NUM_OSTD];
  logic [QPTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [OSTD_W-1:0]       q_cnt_q;
  logic                    q_full, q_empty;

  assign q_full  = (q_cnt_q == OSTD_W'(ATX_NUM_OSTD));
  assign q_empty = (q_cnt_q == '0);
  assign head_id = id_mem[rd_ptr_q];
  assign pop     = bus.tx_done & ~q_empty;

  // First requesting channel at or after rr_q, wrapping upward
  always_comb begin
    int unsigned idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      idx = (32'(rr_q) + i) % CH_NUM;
      if (!gnt_found && bus.ch_req_vld[CH_ID_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_id    = CH_ID_W'(idx);
      end
    end
  end

  assign req_num = bus.ch_req_num_atx[32'(gnt_id)*DMA_LENGTH_W +: DMA_LENGTH_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      cur_id_q <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      cur_id_q <= cur_id_d;
      rr_q     <= rr_d;
    end
  end

  // Grant in IDLE; issue ATXs of one TX at a time in ISSUE
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cur_id_d   = cur_id_q;
    rr_d       = rr_q;
    grant      = 1'b0;
    atx_vld_c  = 1'b0;
    atx_last_c = 1'b0;
    case (state_q)
      IDLE: begin
        // A full queue may still accept a grant when tx_done frees a slot in the same cycle
        if (rst_n && gnt_found && (!q_full || pop)) begin
          grant    = 1'b1;
          rem_d    = (req_num == '0) ? DMA_LENGTH_W'(1) : req_num;
          cur_id_d = gnt_id;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        atx_vld_c  = (32'(ostd_q) < ATX_NUM_OSTD);
        atx_last_c = (rem_q == DMA_LENGTH_W'(1));
        if (atx_vld_c && bus.atx_rdy) begin
          rem_d = rem_q - DMA_LENGTH_W'(1);
          if (atx_last_c) begin
            state_d = IDLE;
            rr_d    = (cur_id_q == CH_ID_W'(CH_NUM - 1)) ? '0 : cur_id_q + CH_ID_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign atx_start_c = atx_vld_c & bus.atx_rdy;

  // Outstanding ATX counter and sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ostd_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (atx_start_c && !bus.atx_done) begin
        ostd_q <= ostd_q + OSTD_W'(1);
      end else if (!atx_start_c && bus.atx_done) begin
        if (ostd_q == '0) err_q  <= 1'b1;
        else              ostd_q <= ostd_q - OSTD_W'(1);
      end
      if (bus.tx_done && q_empty) err_q <= 1'b1;
    end
  end

  // In-order channel-ID queue: push on grant, pop on tx_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_cnt_q  <= '0;
      for (int unsigned i = 0; i < ATX_NUM_OSTD; i++) id_mem[i] <= '0;
    end else begin
      if (grant) begin
        id_mem[wr_ptr_q] <= gnt_id;
        wr_ptr_q <= (wr_ptr_q == QPTR_W'(ATX_NUM_OSTD - 1)) ? '0 : wr_ptr_q + QPTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == QPTR_W'(ATX_NUM_OSTD - 1)) ? '0 : rd_ptr_q + QPTR_W'(1);
      end
      if (grant && !pop)      q_cnt_q <= q_cnt_q + OSTD_W'(1);
      else if (!grant && pop) q_cnt_q <= q_cnt_q - OSTD_W'(1);
    end
  end

  always_comb begin
    bus.ch_req_rdy = '0;
    bus.ch_done    = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      bus.ch_req_rdy[i] = grant && (gnt_id == CH_ID_W'(i));
      bus.ch_done[i]    = pop && (head_id == CH_ID_W'(i));
    end
  end

  assign bus.atx_vld   = atx_vld_c;
  assign bus.atx_last  = atx_last_c;
  assign bus.atx_ch_id = cur_id_q;
  assign bus.atx_start = atx_start_c;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_adma_as_tx_sched.sv
// Directed bench for adma_as_tx_sched: arbitration, ATX split, outstanding cap, ID queue, errors, reset.
module tb_adma_as_tx_sched;
  localparam int unsigned CH_NUM = 4;
  localparam int unsigned DW     = 16;
  localparam int unsigned OSTD   = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  adma_as_tx_sched_if #(.CH_NUM(CH_NUM), .DMA_LENGTH_W(DW)) bus ();

  adma_as_tx_sched #(.CH_NUM(CH_NUM), .DMA_LENGTH_W(DW), .ATX_NUM_OSTD(OSTD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.ch_req_vld     = '0;
    bus.ch_req_num_atx = '0;
    bus.atx_rdy        = 1'b0;
    bus.atx_done       = 1'b0;
    bus.tx_done        = 1'b0;
  endtask

  task automatic set_num(input int ch, input logic [DW-1:0] v);
    bus.ch_req_num_atx[ch*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.ch_req_vld = 4'hF;
    bus.atx_rdy    = 1'b1;
    bus.atx_done   = 1'b1;
    bus.tx_done    = 1'b1;
    set_num(0, 16'd2);
    step();
    checks++; if (bus.ch_req_rdy !== 4'b0000) begin errors++; $display("FAIL rst_rdy: got %b want 0000", bus.ch_req_rdy); end
    checks++; if (bus.ch_done !== 4'b0000) begin errors++; $display("FAIL rst_done: got %b want 0000", bus.ch_done); end
    checks++; if (bus.atx_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b want 0", bus.atx_vld); end
    checks++; if (bus.atx_start !== 1'b0 || bus.atx_last !== 1'b0) begin errors++; $display("FAIL rst_start_last: got %b%b want 00", bus.atx_start, bus.atx_last); end
    checks++; if (bus.atx_ch_id !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d want 0", bus.atx_ch_id); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
  endtask

  task automatic test_single();
    logic exp_last;
    do_reset();
    set_num(1, 16'd3);
    bus.ch_req_vld = 4'b0010;
    bus.atx_rdy    = 1'b1;
    settle();
    checks++; if (bus.ch_req_rdy !== 4'b0010) begin errors++; $display("FAIL t1_grant: got %b want 0010", bus.ch_req_rdy); end
    checks++; if (bus.atx_vld !== 1'b0) begin errors++; $display("FAIL t1_vld_c0: got %b want 0", bus.atx_vld); end
    for (int c = 1; c <= 3; c++) begin
      step();
      bus.ch_req_vld = '0;
      settle();
      exp_last = (c == 3);
      checks++; if (bus.atx_start !== 1'b1) begin errors++; $display("FAIL t1_start c%0d: got %b want 1", c, bus.atx_start); end
      checks++; if (bus.atx_last !== exp_last) begin errors++; $display("FAIL t1_last c%0d: got %b want %b", c, bus.atx_last, exp_last); end
      checks++; if (bus.atx_ch_id !== 2'd1) begin errors++; $display("FAIL t1_id c%0d: got %0d want 1", c, bus.atx_ch_id); end
      checks++; if (bus.ch_req_rdy !== 4'b0000) begin errors++; $display("FAIL t1_rdy c%0d: got %b want 0000", c, bus.ch_req_rdy); end
    end
    step();
    bus.atx_done = 1'b1;
    bus.tx_done  = 1'b1;
    settle();
    checks++; if (bus.atx_vld !== 1'b0) begin errors++; $display("FAIL t1_vld_c4: got %b want 0", bus.atx_vld); end
    checks++; if (bus.ch_done !== 4'b0010) begin errors++; $display("FAIL t1_done: got %b want 0010", bus.ch_done); end
    step();
    bus.tx_done = 1'b0;
    settle();
    checks++; if (bus.ch_done !== 4'b0000) begin errors++; $display("FAIL t1_done_clr: got %b want 0000", bus.ch_done); end
    step();
    step();
    bus.atx_done = 1'b0;
    settle();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL t1_err: got %b want 0", bus.err); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy, exp_done;
    do_reset();
    for (int ch = 0; ch < 4; ch++) set_num(ch, 16'd1);
    bus.atx_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k != 0) step();
      bus.ch_req_vld = 4'hF;
      bus.atx_done   = (k >= 2 && k % 2 == 0);
      bus.tx_done    = (k >= 2 && k % 2 == 0);
      settle();
      if (k % 2 == 0) begin
        exp_rdy  = 4'(1) << ((k / 2) % 4);
        exp_done = (k >= 2) ? 4'(1) << ((k / 2 - 1) % 4) : 4'b0000;
        checks++; if (bus.ch_req_rdy !== exp_rdy) begin errors++; $display("FAIL t2_grant k%0d: got %b want %b", k, bus.ch_req_rdy, exp_rdy); end
        checks++; if (bus.ch_done !== exp_done) begin errors++; $display("FAIL t2_done k%0d: got %b want %b", k, bus.ch_done, exp_done); end
        checks++; if (bus.atx_vld !== 1'b0) begin errors++; $display("FAIL t2_vld k%0d: got %b want 0", k, bus.atx_vld); end
      end else begin
        checks++; if (bus.ch_req_rdy !== 4'b0000) begin errors++; $display("FAIL t2_no_grant k%0d: got %b want 0000", k, bus.ch_req_rdy); end
        checks++; if (bus.atx_start !== 1'b1 || bus.atx_last !== 1'b1) begin errors++; $display("FAIL t2_issue k%0d: got start=%b last=%b want 1 1", k, bus.atx_start, bus.atx_last); end
        checks++; if (32'(bus.atx_ch_id) !== (k / 2) % 4) begin errors++; $display("FAIL t2_id k%0d: got %0d want %0d", k, bus.atx_ch_id, (k / 2) % 4); end
      end
    end
    step();
    bus.ch_req_vld = '0;
    bus.atx_done   = 1'b1;
    bus.tx_done    = 1'b1;
    settle();
    checks++; if (bus.ch_done !== 4'b0001) begin errors++; $display("FAIL t2_last_done: got %b want 0001", bus.ch_done); end
    step();
    bus.atx_done = 1'b0;
    bus.tx_done  = 1'b0;
  endtask

  task automatic test_ostd_cap();
    int pre, post;
    pre  = 0;
    post = 0;
    do_reset();
    set_num(0, 16'd6);
    bus.ch_req_vld = 4'b0001;
    bus.atx_rdy    = 1'b1;
    settle();
    checks++; if (bus.ch_req_rdy !== 4'b0001) begin errors++; $display("FAIL t3_grant: got %b want 0001", bus.ch_req_rdy); end
    for (int c = 1; c <= 12; c++) begin
      step();
      bus.ch_req_vld = '0;
      bus.atx_done   = (c == 7);
      settle();
      if (c == 5) begin
        checks++; if (bus.atx_vld !== 1'b0) begin errors++; $display("FAIL t3_capped: got %b want 0", bus.atx_vld); end
      end
      if (bus.atx_start === 1'b1) begin
        if (c <= 7) pre++;
        else        post++;
      end
    end
    bus.atx_done = 1'b0;
    checks++; if (pre !== 4) begin errors++; $display("FAIL t3_pre_cnt: got %0d want 4", pre); end
    checks++; if (post !== 1) begin errors++; $display("FAIL t3_post_cnt: got %0d want 1", post); end
  endtask

  task automatic test_queue_full();
    logic [3:0] exp_rdy;
    do_reset();
    for (int ch = 0; ch < 4; ch++) set_num(ch, 16'd1);
    bus.atx_rdy = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      if (c != 0) step();
      bus.ch_req_vld = 4'hF;
      bus.tx_done    = (c == 10 || c == 14);
      bus.atx_done   = (c == 11);
      settle();
      if (c <= 6 && c % 2 == 0) begin
        exp_rdy = 4'(1) << (c / 2);
        checks++; if (bus.ch_req_rdy !== exp_rdy) begin errors++; $display("FAIL t4_fill c%0d: got %b want %b", c, bus.ch_req_rdy, exp_rdy); end
      end
      if (c == 8 || c == 9 || c == 13) begin
        checks++; if (bus.ch_req_rdy !== 4'b0000) begin errors++; $display("FAIL t4_full c%0d: got %b want 0000", c, bus.ch_req_rdy); end
      end
      if (c == 10) begin
        checks++; if (bus.ch_done !== 4'b0001) begin errors++; $display("FAIL t4_done0: got %b want 0001", bus.ch_done); end
        checks++; if (bus.ch_req_rdy !== 4'b0001) begin errors++; $display("FAIL t4_regrant: got %b want 0001", bus.ch_req_rdy); end
      end
      if (c == 11) begin
        checks++; if (bus.atx_vld !== 1'b0) begin errors++; $display("FAIL t4_cap: got %b want 0", bus.atx_vld); end
      end
      if (c == 12) begin
        checks++; if (bus.atx_start !== 1'b1 || bus.atx_ch_id !== 2'd0) begin errors++; $display("FAIL t4_issue: got start=%b id=%0d want 1 0", bus.atx_start, bus.atx_ch_id); end
      end
      if (c == 14) begin
        checks++; if (bus.ch_done !== 4'b0010) begin errors++; $display("FAIL t4_done1: got %b want 0010", bus.ch_done); end
        checks++; if (bus.ch_req_rdy !== 4'b0010) begin errors++; $display("FAIL t4_grant1: got %b want 0010", bus.ch_req_rdy); end
      end
    end
  endtask

  task automatic test_zero_len();
    int starts;
    starts = 0;
    do_reset();
    set_num(2, 16'd0);
    bus.ch_req_vld = 4'b0100;
    bus.atx_rdy    = 1'b1;
    settle();
    checks++; if (bus.ch_req_rdy !== 4'b0100) begin errors++; $display("FAIL t5_grant: got %b want 0100", bus.ch_req_rdy); end
    step();
    bus.ch_req_vld = '0;
    settle();
    checks++; if (bus.atx_start !== 1'b1 || bus.atx_last !== 1'b1 || bus.atx_ch_id !== 2'd2) begin errors++; $display("FAIL t5_issue: got start=%b last=%b id=%0d want 1 1 2", bus.atx_start, bus.atx_last, bus.atx_ch_id); end
    step();
    bus.atx_done = 1'b1;
    bus.tx_done  = 1'b1;
    settle();
    checks++; if (bus.atx_vld !== 1'b0) begin errors++; $display("FAIL t5_single: got %b want 0", bus.atx_vld); end
    checks++; if (bus.ch_done !== 4'b0100) begin errors++; $display("FAIL t5_done: got %b want 0100", bus.ch_done); end
    step();
    settle();
    checks++; if (bus.ch_done !== 4'b0000) begin errors++; $display("FAIL t5_empty_done: got %b want 0000", bus.ch_done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL t5_err_pre: got %b want 0", bus.err); end
    step();
    bus.atx_done = 1'b0;
    bus.tx_done  = 1'b0;
    set_num(0, 16'd6);
    bus.ch_req_vld = 4'b0001;
    settle();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL t5_err: got %b want 1", bus.err); end
    checks++; if (bus.ch_req_rdy !== 4'b0001) begin errors++; $display("FAIL t5_wrap_grant: got %b want 0001", bus.ch_req_rdy); end
    for (int c = 0; c < 8; c++) begin
      step();
      bus.ch_req_vld = '0;
      settle();
      if (bus.atx_start === 1'b1) starts++;
    end
    checks++; if (starts !== 4) begin errors++; $display("FAIL t5_ostd_intact: got %0d starts want 4", starts); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL t5_err_sticky: got %b want 1", bus.err); end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    set_num(1, 16'd4);
    bus.ch_req_vld = 4'b0010;
    bus.atx_rdy    = 1'b1;
    settle();
    step();
    bus.ch_req_vld = '0;
    step();
    step();
    settle();
    checks++; if (bus.atx_start !== 1'b1 || bus.atx_last !== 1'b0 || bus.atx_ch_id !== 2'd1) begin errors++; $display("FAIL t6_pre: got start=%b last=%b id=%0d want 1 0 1", bus.atx_start, bus.atx_last, bus.atx_ch_id); end
    rst_n          = 1'b0;
    bus.ch_req_vld = 4'hF;
    bus.tx_done    = 1'b1;
    settle();
    checks++; if (bus.atx_vld !== 1'b0 || bus.atx_start !== 1'b0 || bus.atx_last !== 1'b0) begin errors++; $display("FAIL t6_atx_zero: got vld=%b start=%b last=%b want 0 0 0", bus.atx_vld, bus.atx_start, bus.atx_last); end
    checks++; if (bus.ch_req_rdy !== 4'b0000 || bus.ch_done !== 4'b0000) begin errors++; $display("FAIL t6_ch_zero: got rdy=%b done=%b want 0000 0000", bus.ch_req_rdy, bus.ch_done); end
    checks++; if (bus.atx_ch_id !== 2'd0 || bus.err !== 1'b0) begin errors++; $display("FAIL t6_id_err: got id=%0d err=%b want 0 0", bus.atx_ch_id, bus.err); end
    step();
    bus.tx_done = 1'b0;
    rst_n       = 1'b1;
    settle();
    checks++; if (bus.ch_req_rdy !== 4'b0001) begin errors++; $display("FAIL t6_rr_restart: got %b want 0001", bus.ch_req_rdy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL t6_err: got %b want 0", bus.err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ostd_cap();
    test_queue_full();
    test_zero_len();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
